// File: rtl/dsp_mac_pipe.sv
// Signed multiply-accumulate datapath with valid/ready handshakes and a run-time selectable
// output depth. Define DSP_SAT_EN to clamp results to the signed 2*WIDTH range and flag them.
module dsp_mac_pipe #(
    parameter int unsigned WIDTH         = 33,
    parameter int unsigned SHIFT_BITS    = 2,
    parameter int unsigned PIPELINE_BITS = 3,
    parameter int unsigned MAX_STAGES    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         aa,
    input  logic [WIDTH-1:0]         bb,
    input  logic [2*WIDTH-1:0]       cc,
    input  logic [1:0]               mode,
    input  logic                     mac,
    input  logic                     clr,
    input  logic                     shift_dir,
    input  logic [SHIFT_BITS-1:0]    shift_amount,
    input  logic [PIPELINE_BITS-1:0] pipe_stages,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH-1:0]       out,
    output logic                     out_sat,
    output logic                     busy
);
    localparam int unsigned H  = WIDTH / 2 + 1;
    localparam int unsigned W2 = 2 * WIDTH;
`ifdef DSP_SAT_EN
    localparam int unsigned RW = W2 + 2 ** SHIFT_BITS;
`else
    localparam int unsigned RW = W2;
`endif

    logic signed [RW-1:0]     w_prod;
    logic signed [RW-1:0]     w_acc_ext;
    logic signed [RW-1:0]     w_addend;
    logic signed [RW-1:0]     w_res;
    logic        [W2-1:0]     w_res_fin;
    logic                     w_res_sat;
    logic                     w_stall;
    logic                     w_accept;
    logic                     w_out_valid;
    logic        [W2-1:0]     w_out_data;
    logic                     w_out_sat;
    logic [PIPELINE_BITS-1:0] w_depth_req;

    logic signed [W2-1:0]     r_acc;
    logic                     r_acc_valid;
    logic [PIPELINE_BITS-1:0] r_depth;
    logic        [W2-1:0]     r_c_data;
    logic                     r_c_valid;
    logic                     r_c_sat;
    logic        [W2-1:0]     r_s_data [MAX_STAGES];
    logic [MAX_STAGES-1:0]    r_s_valid;
    logic [MAX_STAGES-1:0]    r_s_sat;

    assign w_stall     = w_out_valid & ~out_ready;
    assign in_ready    = ~w_stall;
    assign w_accept    = in_valid & in_ready;
    assign busy        = r_c_valid | (|r_s_valid);
    assign w_depth_req = (pipe_stages > PIPELINE_BITS'(MAX_STAGES)) ?
                         PIPELINE_BITS'(MAX_STAGES) : pipe_stages;

    always_comb begin
        w_prod = '0;
        case (mode)
            2'b00:   w_prod = RW'($signed(aa[H-1:0])) * RW'($signed(bb[H-1:0]));
            2'b01:   w_prod = RW'($signed(aa[H-1:0])) * RW'($signed(bb));
            2'b10:   w_prod = RW'($signed(aa)) * RW'($signed(bb));
            default: w_prod = RW'($signed(aa[H-1:0])) * RW'($signed(bb[H-1:0]))
                            + RW'($signed(aa[WIDTH-1:H])) * RW'($signed(bb[WIDTH-1:H]));
        endcase
    end

    // The chain continues only when a live accumulator exists and clr is not requested.
    always_comb begin
        w_acc_ext = RW'(r_acc);
        if (mac && r_acc_valid && !clr) begin
            w_addend = shift_dir ? (w_acc_ext << shift_amount) : (w_acc_ext >>> shift_amount);
        end else begin
            w_addend = RW'($signed(cc));
        end
        w_res = w_prod + w_addend;
    end

`ifdef DSP_SAT_EN
    always_comb begin
        w_res_sat = (w_res[RW-1:W2-1] != {(RW-W2+1){w_res[RW-1]}});
        if (!w_res_sat) begin
            w_res_fin = w_res[W2-1:0];
        end else if (w_res[RW-1]) begin
            w_res_fin = {1'b1, {(W2-1){1'b0}}};
        end else begin
            w_res_fin = {1'b0, {(W2-1){1'b1}}};
        end
    end
`else
    assign w_res_fin = w_res[W2-1:0];
    assign w_res_sat = 1'b0;
`endif

    always_comb begin
        w_out_valid = r_c_valid;
        w_out_data  = r_c_data;
        w_out_sat   = r_c_sat;
        for (int i = 0; i < MAX_STAGES; i++) begin
            if (r_depth == PIPELINE_BITS'(i + 1)) begin
                w_out_valid = r_s_valid[i];
                w_out_data  = r_s_data[i];
                w_out_sat   = r_s_sat[i];
            end
        end
    end

    assign out_valid = w_out_valid;
    assign out       = w_out_valid ? w_out_data : '0;
    assign out_sat   = w_out_valid & w_out_sat;

    // Stages beyond the active depth are forced empty so a later depth increase sees no stale beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_acc_valid <= 1'b0;
            r_depth     <= '0;
            r_c_data    <= '0;
            r_c_valid   <= 1'b0;
            r_c_sat     <= 1'b0;
            r_s_valid   <= '0;
            r_s_sat     <= '0;
            for (int i = 0; i < MAX_STAGES; i++) begin
                r_s_data[i] <= '0;
            end
        end else begin
            if (!busy && !w_accept) begin
                r_depth <= w_depth_req;
            end
            if (w_accept) begin
                r_acc       <= w_res_fin;
                r_acc_valid <= 1'b1;
            end
            if (!w_stall) begin
                r_c_valid <= w_accept;
                r_c_data  <= w_accept ? w_res_fin : '0;
                r_c_sat   <= w_accept & w_res_sat;
                if (r_depth != '0) begin
                    r_s_valid[0] <= r_c_valid;
                    r_s_data[0]  <= r_c_data;
                    r_s_sat[0]   <= r_c_sat;
                end else begin
                    r_s_valid[0] <= 1'b0;
                    r_s_data[0]  <= '0;
                    r_s_sat[0]   <= 1'b0;
                end
                for (int i = 1; i < MAX_STAGES; i++) begin
                    if (PIPELINE_BITS'(i) < r_depth) begin
                        r_s_valid[i] <= r_s_valid[i-1];
                        r_s_data[i]  <= r_s_data[i-1];
                        r_s_sat[i]   <= r_s_sat[i-1];
                    end else begin
                        r_s_valid[i] <= 1'b0;
                        r_s_data[i]  <= '0;
                        r_s_sat[i]   <= 1'b0;
                    end
                end
            end
        end
    end
endmodule
